gray_ptr_tracker: RTL

Consumer-side tracker for the Gray-coded count produced by the up/Gray counter stage. It double-flop synchronises the incoming Gray count and decodes it to binary. It keeps a local read pointer advanced by a pop handshake, and reports occupancy, empty, full, Gray-step errors and overrun. It sits directly downstream of the counter and forms the read side of a pointer-based FIFO/credit scheme.

---
 rtl/gray_ptr_tracker_if.sv | 29 ++
 rtl/gray_ptr_tracker.sv | 82 ++++++++
 2 files changed

// File: rtl/gray_ptr_tracker_if.sv
// Bus between the Gray pointer tracker and its consumer: the Gray count and pop
// request go in; the pointers, occupancy and status flags come back.
interface gray_ptr_tracker_if #(
    parameter int BITS = 3
);
    logic [BITS-1:0] i_g_in;
    logic            i_pop;
    logic            o_pop_ack;
    logic [BITS-1:0] o_g_sync;
    logic [BITS-1:0] o_b_sync;
    logic [BITS-1:0] o_rd_ptr;
    logic [BITS-1:0] o_occupancy;
    logic            o_empty;
    logic            o_full;
    logic            o_gray_err;
    logic            o_overrun;

    modport master (
        output i_g_in, i_pop,
        input  o_pop_ack, o_g_sync, o_b_sync, o_rd_ptr, o_occupancy,
        input  o_empty, o_full, o_gray_err, o_overrun
    );

    modport slave (
        input  i_g_in, i_pop,
        output o_pop_ack, o_g_sync, o_b_sync, o_rd_ptr, o_occupancy,
        output o_empty, o_full, o_gray_err, o_overrun
    );
endinterface

// File: rtl/gray_ptr_tracker.sv
// Read-side tracker: synchronises an upstream Gray count, decodes it to binary,
// and maintains a local read pointer with occupancy, Gray-step and overrun flags.
module gray_ptr_tracker #(
    parameter int BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    gray_ptr_tracker_if.slave   bus
);

    function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b[BITS-1] = g[BITS-1];
        for (int i = BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [BITS-1:0] r_s1;
    logic [BITS-1:0] r_s2;
    logic [BITS-1:0] r_g_prev;
    logic [BITS-1:0] r_b_sync;
    logic [BITS-1:0] r_rd_ptr;
    logic            r_gray_err;
    logic            r_overrun;

    logic [BITS-1:0] w_b_next;
    logic [BITS-1:0] w_diff;
    logic            w_multi_bit;
    logic [BITS-1:0] w_occupancy;
    logic            w_empty;
    logic            w_full;
    logic            w_pop_ack;

    assign w_b_next    = gray2bin(r_s2);
    assign w_diff      = r_s2 ^ r_g_prev;
    // Clearing the lowest set bit leaves something only if two or more bits differ.
    assign w_multi_bit = (w_diff & (w_diff - BITS'(1))) != '0;
    assign w_occupancy = r_b_sync - r_rd_ptr;
    assign w_empty     = (w_occupancy == '0);
    assign w_full      = (w_occupancy == '1);
    assign w_pop_ack   = bus.i_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_g_prev   <= '0;
            r_b_sync   <= '0;
            r_rd_ptr   <= '0;
            r_gray_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_s1     <= bus.i_g_in;
            r_s2     <= r_s1;
            r_g_prev <= r_s2;
            r_b_sync <= w_b_next;
            if (w_multi_bit) begin
                r_gray_err <= 1'b1;
            end
            // b_sync still advances on an overrun; occupancy aliases from here on.
            if ((w_b_next != r_b_sync) && w_full && !w_pop_ack) begin
                r_overrun <= 1'b1;
            end
            if (w_pop_ack) begin
                r_rd_ptr <= r_rd_ptr + BITS'(1);
            end
        end
    end

    assign bus.o_pop_ack   = w_pop_ack;
    assign bus.o_g_sync    = r_s2;
    assign bus.o_b_sync    = r_b_sync;
    assign bus.o_rd_ptr    = r_rd_ptr;
    assign bus.o_occupancy = w_occupancy;
    assign bus.o_empty     = w_empty;
    assign bus.o_full      = w_full;
    assign bus.o_gray_err  = r_gray_err;
    assign bus.o_overrun   = r_overrun;

endmodule
